uart_rx_8n1: RTL and testbench
==============================

UART_RX_8N1 -- requirements
Module: uart_rx_8n1

Interface
REQ-001 Parameter CLKS_PER_BIT, default 104, clk cycles per UART bit (12 MHz / 115200); SHALL be >= 8.
REQ-002 Port clk, input, 1, system clock; all logic on rising edge; single clock domain.
REQ-003 Port rst, input, 1, synchronous active-high reset.
REQ-004 Port uart_rx, input, 1, asynchronous serial line; idle high; 8N1, LSB first.
REQ-005 Port rx_data, output, 8, last correctly framed byte; holds until the next good frame.
REQ-006 Port rx_valid, output, 1, one-cycle pulse when rx_data is updated.
REQ-007 Port rx_frame_err, output, 1, one-cycle pulse when the stop bit samples low.
REQ-008 Port rx_busy, output, 1, high in every state except IDLE.

Function
REQ-009 uart_rx SHALL pass through a 2-flop synchronizer; all decoding uses the synchronized value rx_s (2-cycle delay).
REQ-010 States SHALL be IDLE, START, DATA, STOP and BREAK_WAIT.
REQ-011 IDLE: rx_s==0 -> START, bit counter cleared; otherwise stay in IDLE.
REQ-012 START: at counter == CLKS_PER_BIT/2-1 (integer division), sample rx_s.
- 0 -> DATA, counter and bit index cleared.
- 1 -> IDLE (glitch rejected, no output pulse).
REQ-013 DATA: each time the counter reaches CLKS_PER_BIT-1, sample rx_s into the shift register (LSB first), clear the counter and increment the 3-bit bit index.
- After the sample at index 7 -> STOP.
REQ-014 STOP: at counter == CLKS_PER_BIT-1, sample rx_s.
- 1 -> load rx_data from the shift register, pulse rx_valid, go to IDLE.
- 0 -> pulse rx_frame_err, leave rx_data unchanged, go to BREAK_WAIT.
REQ-015 BREAK_WAIT: stay until rx_s==1, then go to IDLE; a held-low line SHALL yield exactly one rx_frame_err pulse.
REQ-016 rx_valid and rx_frame_err SHALL be registered, mutually exclusive, and high for exactly one cycle, the cycle after the stop-bit sample edge.
REQ-017 Sample points SHALL fall mid-bit: the data bit n sample occurs CLKS_PER_BIT/2 + (n+1)*CLKS_PER_BIT cycles after START entry, with +/-1 cycle tolerance.
REQ-018 Back-to-back frames (next start bit immediately after the stop bit) SHALL be received without loss, because IDLE is re-entered before the next falling edge is sampled.
REQ-019 Counter width SHALL be clog2(CLKS_PER_BIT); the counter SHALL never wrap inside a bit period.
REQ-020 Line edges during DATA or STOP, other than at sample points, SHALL be ignored (no resynchronization).

Reset
REQ-021 While rst=1 at a clk edge, the following SHALL be set:
- state IDLE;
- counter, bit index and shift register 0;
- rx_data 8'h00;
- rx_valid, rx_frame_err and rx_busy 0;
- synchronizer flops 1.
REQ-022 Reset asserted mid-frame SHALL abort the frame with no pulse; after release, decoding restarts at the next falling edge.
REQ-023 Reset SHALL take priority over every state transition in the same cycle.

Verification (CLKS_PER_BIT=16)
REQ-024 Frame 0x55 with a good stop bit -> exactly one rx_valid pulse, rx_data=8'h55, rx_frame_err stays 0, rx_busy low again after the stop sample.
REQ-025 Frames 0x00, 0xFF, 0xA5 sent back-to-back with no idle gap -> three rx_valid pulses, rx_data sequence 00, FF, A5.
REQ-026 Low glitch of 4 cycles on an idle line -> START entered then IDLE, no rx_valid, no rx_frame_err, rx_data unchanged.
REQ-027 Frame 0x3C with the stop bit driven low, then the line held low for 40 bit times -> one rx_frame_err pulse, no rx_valid, rx_data unchanged, rx_busy high until the line returns high.
REQ-028 rst pulsed during bit 4 of frame 0x81 -> no pulse for that frame; a following 0x81 frame -> rx_valid with rx_data=8'h81.
REQ-029 Frame bit periods stretched to 17 and shrunk to 15 cycles, byte 0xC3 -> received correctly in both cases.

Source files
------------

// File: rtl/uart_rx_8n1.sv
// uart_rx_8n1: 8N1 UART receiver with mid-bit sampling, framing-error detection and break wait
module uart_rx_8n1 #(
    parameter int CLKS_PER_BIT = 104
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       uart_rx,
    output logic [7:0] rx_data,
    output logic       rx_valid,
    output logic       rx_frame_err,
    output logic       rx_busy
);
    localparam int CW = $clog2(CLKS_PER_BIT);
    localparam logic [CW-1:0] HALF = CW'(CLKS_PER_BIT / 2 - 1);
    localparam logic [CW-1:0] LAST = CW'(CLKS_PER_BIT - 1);

    typedef enum logic [2:0] {IDLE, START, DATA, STOP, BREAK_WAIT} state_t;

    state_t        state, state_n;
    logic          rx_m, rx_s;
    logic [CW-1:0] cnt;
    logic [2:0]    idx;
    logic [7:0]    shift;
    logic          half_hit, bit_hit, valid_n, err_n;

    assign half_hit = cnt == HALF;
    assign bit_hit  = cnt == LAST;

    // two-flop synchronizer; idles high so reset never looks like a start bit
    always_ff @(posedge clk) begin
        if (rst) {rx_m, rx_s} <= 2'b11;
        else     {rx_m, rx_s} <= {uart_rx, rx_m};
    end

    // state register
    always_ff @(posedge clk) begin
        if (rst) state <= IDLE;
        else     state <= state_n;
    end

    // next-state decode, only ever looking at the synchronized line
    always_comb begin
        state_n = state;
        case (state)
            IDLE:       state_n = rx_s ? IDLE : START;
            START:      state_n = !half_hit ? START : (rx_s ? IDLE : DATA);
            DATA:       state_n = (bit_hit && idx == 3'd7) ? STOP : DATA;
            STOP:       state_n = !bit_hit ? STOP : (rx_s ? IDLE : BREAK_WAIT);
            BREAK_WAIT: state_n = rx_s ? IDLE : BREAK_WAIT;
            default:    state_n = IDLE;
        endcase
    end

    // outputs: busy from state, pulse requests at the stop-bit sample
    always_comb begin
        rx_busy = state != IDLE;
        valid_n = state == STOP && bit_hit && rx_s;
        err_n   = state == STOP && bit_hit && !rx_s;
    end

    // bit timer, shift register and registered result outputs
    always_ff @(posedge clk) begin
        if (rst) begin
            cnt          <= '0;
            idx          <= '0;
            shift        <= '0;
            rx_data      <= '0;
            rx_valid     <= 1'b0;
            rx_frame_err <= 1'b0;
        end else begin
            cnt          <= (state == IDLE || state == BREAK_WAIT || state != state_n || bit_hit) ? '0 : cnt + 1'b1;
            idx          <= state != DATA ? '0 : (bit_hit ? idx + 1'b1 : idx);
            shift        <= (state == DATA && bit_hit) ? {rx_s, shift[7:1]} : shift;
            rx_data      <= valid_n ? shift : rx_data;
            rx_valid     <= valid_n;
            rx_frame_err <= err_n;
        end
    end
endmodule

// File: tb/tb_uart_rx_8n1.sv
// tb_uart_rx_8n1: directed and randomized frames against a byte/event-level scoreboard
module tb_uart_rx_8n1;
    localparam int CPB = 16;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       uart_rx = 1'b1;
    logic [7:0] rx_data;
    logic       rx_valid, rx_frame_err, rx_busy;

    int vectors = 0;
    int errors = 0;
    int got_err = 0;
    int exp_err = 0;
    int both = 0;
    logic [7:0] last_good = 8'h00;
    logic [7:0] got_q[$];
    logic [7:0] exp_q[$];
    time        got_t[$];
    time        exp_t[$];

    uart_rx_8n1 #(.CLKS_PER_BIT(CPB)) dut (
        .clk(clk), .rst(rst), .uart_rx(uart_rx),
        .rx_data(rx_data), .rx_valid(rx_valid), .rx_frame_err(rx_frame_err), .rx_busy(rx_busy)
    );

    always #5 clk = ~clk;

    // record every result pulse, away from the active edge
    always @(negedge clk) begin
        if (!rst) begin
            if (rx_valid) begin
                got_q.push_back(rx_data);
                got_t.push_back($time);
            end
            if (rx_frame_err) got_err++;
            if (rx_valid && rx_frame_err) both++;
        end
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic idle(input int n);
        repeat (n) begin
            @(negedge clk);
            uart_rx = 1'b1;
        end
    endtask

    // one frame with bit period bl; rst is high for frame cycles [ra, rb)
    task automatic send(input logic [7:0] b, input logic stop, input int bl, input int ra = -1, input int rb = -1);
        logic [9:0] f;
        time t0;
        f = {stop, b, 1'b0};
        t0 = 0;
        for (int c = 0; c < 10 * bl; c++) begin
            @(negedge clk);
            uart_rx = f[c / bl];
            rst = c >= ra && c < rb;
            if (c == 0) t0 = $time;
        end
        if (ra >= 0) last_good = 8'h00;
        else if (!stop) exp_err++;
        else begin
            exp_q.push_back(b);
            exp_t.push_back(t0);
            last_good = b;
        end
    endtask

    // compare everything received so far against the expected bytes and events
    task automatic drain(input string tag);
        logic [7:0] g, e;
        time gt, et;
        int lat;
        while (exp_q.size() > 0) begin
            if (got_q.size() == 0) begin
                check({tag, "_missing"}, exp_q.size(), 0);
                exp_q.delete();
                exp_t.delete();
            end else begin
                g = got_q.pop_front();
                gt = got_t.pop_front();
                e = exp_q.pop_front();
                et = exp_t.pop_front();
                check({tag, "_data"}, g, e);
                lat = int'((gt - et) / 10);
                check({tag, "_latency_in_150_158"}, lat >= 150 && lat <= 158, 1);
            end
        end
        check({tag, "_extra_valid"}, got_q.size(), 0);
        got_q.delete();
        got_t.delete();
        check({tag, "_frame_err_count"}, got_err, exp_err);
        check({tag, "_rx_data_hold"}, rx_data, last_good);
    endtask

    initial begin
        repeat (4) @(negedge clk);
        check("rst_rx_data", rx_data, 8'h00);
        check("rst_rx_valid", rx_valid, 0);
        check("rst_rx_frame_err", rx_frame_err, 0);
        check("rst_rx_busy", rx_busy, 0);
        rst = 1'b0;
        idle(5);

        send(8'h55, 1'b1, CPB);
        idle(1);
        check("f55_busy_after_stop", rx_busy, 0);
        idle(20);
        drain("f55");

        send(8'h00, 1'b1, CPB);
        send(8'hFF, 1'b1, CPB);
        send(8'hA5, 1'b1, CPB);
        idle(20);
        drain("b2b");

        repeat (4) begin
            @(negedge clk);
            uart_rx = 1'b0;
        end
        idle(1);
        check("glitch_busy_in_start", rx_busy, 1);
        idle(20);
        check("glitch_busy_after", rx_busy, 0);
        drain("glitch");

        send(8'h3C, 1'b0, CPB);
        repeat (20 * CPB) @(negedge clk);
        check("brk_busy_mid", rx_busy, 1);
        check("brk_err_mid", got_err, exp_err);
        repeat (20 * CPB) @(negedge clk);
        check("brk_busy_end", rx_busy, 1);
        idle(10);
        check("brk_busy_released", rx_busy, 0);
        drain("brk");

        // reset lands mid bit 4 and is held until the line is back high in bit 7
        send(8'h81, 1'b1, CPB, 5 * CPB + 5, 8 * CPB + 4);
        idle(20);
        drain("rst_abort");
        send(8'h81, 1'b1, CPB);
        idle(20);
        drain("rst_after");

        send(8'hC3, 1'b1, 17);
        idle(20);
        send(8'hC3, 1'b1, 15);
        idle(20);
        drain("skew");

        for (int i = 0; i < 30; i++) begin
            logic bad;
            bad = $urandom_range(0, 7) == 0;
            send(8'($urandom), !bad, CPB);
            if (bad) idle(CPB + $urandom_range(0, 20));
            else if ($urandom_range(0, 2) != 0) idle($urandom_range(1, 40));
        end
        idle(30);
        drain("rand");
        check("valid_err_exclusive", both, 0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
        $finish;
    end
endmodule
